// File: rtl/mips_trace_pkg.sv
// Shared types for the mips_top execution trace buffer.
// Entry layout and FSM state encoding used by top and FIFO users.
package mips_trace_pkg;

   localparam int TRACE_PC_W      = 32;
   localparam int TRACE_DATA_W    = 32;
   localparam int TRACE_SEQ_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } trace_state_t;

   typedef struct packed {
      logic [TRACE_SEQ_MAX_W-1:0] seq;
      logic [TRACE_PC_W-1:0]      pc;
      logic [TRACE_DATA_W-1:0]    ula;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head.
// Head register holds its last value when the FIFO drains.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 80
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_n;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_n;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      pop_ok  = pop && !clr && (cnt_q != '0);
      push_ok = push && !clr &&
                ((cnt_q != (AW+1)'(DEPTH)) || pop_ok);
      cnt_n   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      head_n  = head_q;
      // next head: the following slot, or the incoming word if it lands first
      if (cnt_n != '0) begin
         if (pop_ok)
            head_n = (cnt_q == (AW+1)'(1)) ? din : mem[rd_ptr + AW'(1)];
         else if (cnt_q == '0)
            head_n = din;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         cnt_q  <= cnt_n;
         head_q <= head_n;
      end
   end

   assign dout  = head_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign count = cnt_q;

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution trace recorder for mips_top: one entry per PC change, halt detect.
// Define TRACE_DROP_CNT_EN to add the saturating drop_cnt output.
module exec_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4,
   parameter int SEQ_W       = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic [TRACE_PC_W-1:0]    pc_in,
   input  logic [TRACE_DATA_W-1:0]  ula_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TRACE_PC_W-1:0]    out_pc,
   output logic [TRACE_DATA_W-1:0]  out_ula,
   output logic [SEQ_W-1:0]         out_seq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
`ifdef TRACE_DROP_CNT_EN
   output logic [15:0]              drop_cnt,
`endif
   output logic                     halted
);

   localparam int SCW = $clog2(HALT_CYCLES);
   localparam logic [SCW-1:0] HALT_LIM = SCW'(HALT_CYCLES - 1);

   trace_state_t            state_q;
   trace_state_t            state_n;
   logic                    first_q;
   logic [TRACE_PC_W-1:0]   last_pc_q;
   logic [SCW-1:0]          stable_q;
   logic [SEQ_W-1:0]        seq_q;
   logic                    overflow_q;
   logic                    clr;
   logic                    push_req;
   logic                    pc_chg;
   logic                    pop;
   logic                    drop;
   logic                    hold;
   logic                    full;
   logic                    empty;
   trace_entry_t            push_entry;
   trace_entry_t            head;
   logic [$bits(trace_entry_t)-1:0] head_raw;

   always_comb begin
      state_n  = state_q;
      clr      = 1'b0;
      push_req = 1'b0;
      pc_chg   = (pc_in != last_pc_q);
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_n = RUN;
               clr     = 1'b1;
            end
         end
         RUN: begin
            if (stop)
               state_n = IDLE;
            else if (first_q || pc_chg)
               push_req = 1'b1;
            else if (stable_q == HALT_LIM)
               state_n = HALT;
         end
         HALT: begin
            if (stop) begin
               state_n = IDLE;
            end else if (pc_chg) begin
               push_req = 1'b1;
               state_n  = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign pop  = out_valid && out_ready;
   assign drop = push_req && full && !pop;
   assign hold = (state_q != IDLE) && !stop && !push_req;

   always_comb begin
      push_entry     = '0;
      push_entry.seq = TRACE_SEQ_MAX_W'(seq_q);
      push_entry.pc  = pc_in;
      push_entry.ula = ula_in;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         first_q    <= 1'b0;
         last_pc_q  <= '0;
         stable_q   <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_n;
         first_q <= clr;
         if (clr) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            stable_q   <= '0;
         end else if (push_req) begin
            // sequence advances on every attempt so drops leave gaps
            seq_q     <= seq_q + SEQ_W'(1);
            last_pc_q <= pc_in;
            stable_q  <= '0;
         end else if (hold && stable_q != HALT_LIM) begin
            stable_q <= stable_q + SCW'(1);
         end
         if (drop)
            overflow_q <= 1'b1;
      end
   end

`ifdef TRACE_DROP_CNT_EN
   logic [15:0] drop_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         drop_q <= '0;
      else if (clr)
         drop_q <= '0;
      else if (drop && drop_q != 16'hFFFF)
         drop_q <= drop_q + 16'd1;
   end

   assign drop_cnt = drop_q;
`endif

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(trace_entry_t))
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clr   (clr),
      .push  (push_req),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_raw),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head      = trace_entry_t'(head_raw);
   assign out_valid = !empty;
   assign out_pc    = head.pc;
   assign out_ula   = head.ula;
   assign out_seq   = head.seq[SEQ_W-1:0];
   assign overflow  = overflow_q;
   assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Randomized bench for exec_trace_buffer against a queue-based trace model.
// A second instance with SEQ_W=4 shares all inputs to observe sequence wrap.
module tb_exec_trace_buffer;

   localparam int DEPTH = 16;
   localparam int HALT_CYCLES = 4;

   logic        clock;
   logic        reset;
   logic        start;
   logic        stop;
   logic [31:0] pc_in;
   logic [31:0] ula_in;
   logic        out_ready;

   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_ula;
   logic [15:0] out_seq;
   logic [4:0]  count;
   logic        overflow;
   logic        halted;

   logic        out_valid_w;
   logic [31:0] out_pc_w;
   logic [31:0] out_ula_w;
   logic [3:0]  out_seq_w;
   logic [4:0]  count_w;
   logic        overflow_w;
   logic        halted_w;

`ifdef TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt;
   logic [15:0] drop_cnt_w;
`endif

   exec_trace_buffer u_dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .pc_in     (pc_in),
      .ula_in    (ula_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_ula   (out_ula),
      .out_seq   (out_seq),
      .count     (count),
      .overflow  (overflow),
`ifdef TRACE_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .halted    (halted)
   );

   exec_trace_buffer #(.SEQ_W(4)) u_dut_w (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .pc_in     (pc_in),
      .ula_in    (ula_in),
      .out_valid (out_valid_w),
      .out_ready (out_ready),
      .out_pc    (out_pc_w),
      .out_ula   (out_ula_w),
      .out_seq   (out_seq_w),
      .count     (count_w),
      .overflow  (overflow_w),
`ifdef TRACE_DROP_CNT_EN
      .drop_cnt  (drop_cnt_w),
`endif
      .halted    (halted_w)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   typedef struct {
      int unsigned seq;
      logic [31:0] pc;
      logic [31:0] ula;
   } ent_t;

   ent_t        q[$];
   ent_t        last_out;
   bit          m_run;
   bit          m_first;
   logic [31:0] m_last_pc;
   int          m_eq;
   int unsigned m_seq;
   bit          m_ovf;
   int          m_drops;
   bit          m_halt;

   int n_chk;
   int n_err;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_out  = '{0, 32'h0, 32'h0};
      m_run     = 0;
      m_first   = 0;
      m_last_pc = 32'h0;
      m_eq      = 0;
      m_seq     = 0;
      m_ovf     = 0;
      m_drops   = 0;
      m_halt    = 0;
   endtask

   task automatic model_step(input logic [31:0] pc, input logic [31:0] ula,
                             input bit st, input bit sp, input bit rdy);
      bit att;
      att = 0;
      if (rdy && q.size() > 0)
         void'(q.pop_front());
      if (sp) begin
         m_run   = 0;
         m_halt  = 0;
         m_first = 0;
      end else if (!m_run) begin
         if (st) begin
            q.delete();
            m_run    = 1;
            m_first  = 1;
            m_seq    = 0;
            m_ovf    = 0;
            m_drops  = 0;
            m_eq     = 0;
            last_out = '{0, 32'h0, 32'h0};
         end
      end else if (m_first || pc != m_last_pc) begin
         att       = 1;
         m_first   = 0;
         m_eq      = 0;
         m_halt    = 0;
         m_last_pc = pc;
      end else begin
         m_eq++;
         if (m_eq >= HALT_CYCLES)
            m_halt = 1;
      end
      if (att) begin
         if (q.size() < DEPTH) begin
            q.push_back('{m_seq, pc, ula});
         end else begin
            m_ovf = 1;
            if (m_drops < 65535)
               m_drops++;
         end
         m_seq++;
      end
      if (q.size() > 0)
         last_out = q[0];
   endtask

   task automatic check_all();
      logic [31:0] s;
      s = last_out.seq;
      chk("valid", out_valid, q.size() > 0);
      chk("count", count, q.size());
      chk("overflow", overflow, m_ovf);
      chk("halted", halted, m_halt);
      chk("out_pc", out_pc, last_out.pc);
      chk("out_ula", out_ula, last_out.ula);
      chk("out_seq", out_seq, s[15:0]);
      chk("valid_w", out_valid_w, q.size() > 0);
      chk("count_w", count_w, q.size());
      chk("out_seq_w", out_seq_w, s[3:0]);
`ifdef TRACE_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, m_drops);
      chk("drop_cnt_w", drop_cnt_w, m_drops);
`endif
   endtask

   task automatic cyc(input logic [31:0] pc, input logic [31:0] ula,
                      input bit st, input bit sp, input bit rdy);
      pc_in     = pc;
      ula_in    = ula;
      start     = st;
      stop      = sp;
      out_ready = rdy;
      model_step(pc, ula, st, sp, rdy);
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic reset_pulse();
      start  = 0;
      stop   = 0;
      reset  = 0;
      model_reset();
      #2;
      check_all();
      #3;
      reset = 1;
   endtask

   initial begin
      logic [31:0] pc;
      n_chk     = 0;
      n_err     = 0;
      reset     = 0;
      start     = 0;
      stop      = 0;
      pc_in     = 0;
      ula_in    = 0;
      out_ready = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset = 1;

      // basic capture
      cyc(32'h0, 32'h0, 1, 0, 1);
      cyc(32'h0, 32'h5, 0, 0, 1);
      cyc(32'h4, 32'hA, 0, 0, 1);
      cyc(32'h8, 32'hF, 0, 0, 1);
      cyc(32'hC, 32'h14, 0, 0, 1);

      // halt on self-loop, resume on PC change
      for (int i = 0; i < 5; i++)
         cyc(32'h10, 32'h33, 0, 0, 1);
      cyc(32'h14, 32'h44, 0, 0, 1);
      cyc(32'h14, 32'h44, 0, 0, 1);

      // overflow, then full push+pop
      cyc(32'h14, 32'h0, 0, 1, 1);
      cyc(32'h14, 32'h0, 1, 0, 1);
      for (int i = 0; i < 20; i++)
         cyc(32'h200 + 32'(i) * 4, $urandom, 0, 0, 0);
      cyc(32'h300, 32'hABCD, 0, 0, 1);
      cyc(32'h300, 32'h0, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         cyc(32'h300, 32'h0, 0, 0, 1);

      // start+stop together leaves the tracer idle
      cyc(32'h300, 32'h0, 0, 1, 1);
      cyc(32'h304, 32'h1, 1, 1, 1);
      cyc(32'h308, 32'h2, 0, 0, 1);
      cyc(32'h30C, 32'h3, 0, 0, 1);

      // asynchronous reset mid-run
      cyc(32'h400, 32'h0, 1, 0, 0);
      for (int i = 0; i < 7; i++)
         cyc(32'h400 + 32'(i) * 4, $urandom, 0, 0, 0);
      reset_pulse();
      for (int i = 0; i < 5; i++)
         cyc(32'h500 + 32'(i) * 4, $urandom, 0, 0, 1);

      // long run so the narrow instance wraps its sequence
      cyc(32'h600, 32'h0, 1, 0, 1);
      for (int i = 0; i < 40; i++)
         cyc(32'h600 + 32'(i) * 4, $urandom, 0, 0, ($urandom_range(0, 3) != 0));

      // random traffic
      pc = 32'h0;
      for (int i = 0; i < 600; i++) begin
         bit rdy;
         if ($urandom_range(0, 1) == 0)
            pc = 32'($urandom_range(0, 7)) << 2;
         rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 5) == 0);
         cyc(pc, $urandom, ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 60) == 0), rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
